// File: rtl/lane_pkg.sv
// Shared types for the ramp arbiter: FSM state encoding, direction codes and
// sensor patterns written as {sensor_a, sensor_b}, both active low.
package lane_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        IN_WAIT  = 4'd1,
        IN_A     = 4'd2,
        IN_AB    = 4'd3,
        IN_B     = 4'd4,
        OUT_WAIT = 4'd5,
        OUT_B    = 4'd6,
        OUT_BA   = 4'd7,
        OUT_A    = 4'd8
    } lane_state_e;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    localparam logic [1:0] CLEAR  = 2'b11;
    localparam logic [1:0] A_ONLY = 2'b01;
    localparam logic [1:0] BOTH   = 2'b00;
    localparam logic [1:0] B_ONLY = 2'b10;

    function automatic logic is_in_state(input lane_state_e s);
        return (s == IN_WAIT) || (s == IN_A) || (s == IN_AB) || (s == IN_B);
    endfunction

    function automatic logic is_out_state(input lane_state_e s);
        return (s == OUT_WAIT) || (s == OUT_B) || (s == OUT_BA) || (s == OUT_A);
    endfunction

endpackage

// File: rtl/lane_arbiter_if.sv
// Request, sensor, grant and occupancy signals of the ramp arbiter.
// master = gate/request side driving requests and sensors; slave = arbiter.
interface lane_arbiter_if #(
    parameter int COUNT_W = 3
);
    logic               req_in;
    logic               req_out;
    logic               sensor_a;
    logic               sensor_b;
    logic               grant_in;
    logic               grant_out;
    logic [COUNT_W-1:0] count;
    logic               full;
    logic               empty;

    modport master (
        output req_in, req_out, sensor_a, sensor_b,
        input  grant_in, grant_out, count, full, empty
    );

    modport slave (
        input  req_in, req_out, sensor_a, sensor_b,
        output grant_in, grant_out, count, full, empty
    );
endinterface

// File: rtl/lane_arbiter_sensor_sync.sv
// Two-flop synchronizer for the beam sensors; 2-cycle latency, no backpressure.
// Resets to all ones so a reset never looks like a blocked beam.
module sensor_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);
    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q;
endmodule

// File: rtl/lane_arbiter.sv
// Single-lane ramp arbiter: grants entry/exit one at a time, tracks the car over the
// sensor pair and updates occupancy; grant 1 cycle after request, LANE_SENSOR_SYNC_EN adds 2-cycle sensor sync.
module lane_arbiter
    import lane_pkg::*;
#(
    parameter int CAPACITY = 7,
    parameter int COUNT_W  = 3,
    parameter int TIMEOUT  = 16,
    parameter int TIMER_W  = 5
) (
    input  logic           clk,
    input  logic           reset,
    lane_arbiter_if.slave  lane
);
    lane_state_e        state_d, state_q;
    logic [TIMER_W-1:0] timer_d, timer_q;
    logic [COUNT_W-1:0] count_d, count_q;
    logic               last_dir_d, last_dir_q;
    logic               grant_in_d, grant_in_q;
    logic               grant_out_d, grant_out_q;

    logic [1:0] sens_raw;
    logic [1:0] sens;
    logic       full;
    logic       empty;
    logic       elig_in;
    logic       elig_out;

    assign sens_raw = {lane.sensor_a, lane.sensor_b};

`ifdef LANE_SENSOR_SYNC_EN
    sensor_sync #(.WIDTH(2)) u_sensor_sync (
        .clk   (clk),
        .reset (reset),
        .d_in  (sens_raw),
        .q_out (sens)
    );
`else
    assign sens = sens_raw;
`endif

    assign full     = (count_q == COUNT_W'(CAPACITY));
    assign empty    = (count_q == '0);
    assign elig_in  = lane.req_in & ~full;
    assign elig_out = lane.req_out & ~empty;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        count_d    = count_q;
        last_dir_d = last_dir_q;

        unique case (state_q)
            IDLE: begin
                // On a tie, serve whichever direction was not granted last.
                if (elig_in && (!elig_out || last_dir_q == DIR_OUT)) begin
                    state_d    = IN_WAIT;
                    timer_d    = '0;
                    last_dir_d = DIR_IN;
                end else if (elig_out) begin
                    state_d    = OUT_WAIT;
                    timer_d    = '0;
                    last_dir_d = DIR_OUT;
                end
            end
            IN_WAIT: begin
                if (sens == A_ONLY)                           state_d = IN_A;
                else if (!lane.req_in)                        state_d = IDLE;
                else if (timer_q == TIMER_W'(TIMEOUT - 1))    state_d = IDLE;
                else                                          timer_d = timer_q + TIMER_W'(1);
            end
            IN_A: begin
                if (sens == BOTH) begin
                    state_d = IN_AB;
                end else if (sens == CLEAR) begin
                    state_d = IN_WAIT;
                    timer_d = '0;
                end
            end
            IN_AB: begin
                if (sens == B_ONLY)      state_d = IN_B;
                else if (sens == A_ONLY) state_d = IN_A;
            end
            IN_B: begin
                if (sens == CLEAR) begin
                    state_d = IDLE;
                    count_d = count_q + COUNT_W'(1);
                end else if (sens == BOTH) begin
                    state_d = IN_AB;
                end
            end
            OUT_WAIT: begin
                if (sens == B_ONLY)                           state_d = OUT_B;
                else if (!lane.req_out)                       state_d = IDLE;
                else if (timer_q == TIMER_W'(TIMEOUT - 1))    state_d = IDLE;
                else                                          timer_d = timer_q + TIMER_W'(1);
            end
            OUT_B: begin
                if (sens == BOTH) begin
                    state_d = OUT_BA;
                end else if (sens == CLEAR) begin
                    state_d = OUT_WAIT;
                    timer_d = '0;
                end
            end
            OUT_BA: begin
                if (sens == A_ONLY)      state_d = OUT_A;
                else if (sens == B_ONLY) state_d = OUT_B;
            end
            OUT_A: begin
                if (sens == CLEAR) begin
                    state_d = IDLE;
                    count_d = count_q - COUNT_W'(1);
                end else if (sens == BOTH) begin
                    state_d = OUT_BA;
                end
            end
            default: state_d = IDLE;
        endcase

        // Grants are registered from the next state so they drop with the count update.
        grant_in_d  = is_in_state(state_d);
        grant_out_d = is_out_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            count_q     <= '0;
            last_dir_q  <= DIR_OUT;
            grant_in_q  <= 1'b0;
            grant_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            last_dir_q  <= last_dir_d;
            grant_in_q  <= grant_in_d;
            grant_out_q <= grant_out_d;
        end
    end

    assign lane.grant_in  = grant_in_q;
    assign lane.grant_out = grant_out_q;
    assign lane.count     = count_q;
    assign lane.full      = full;
    assign lane.empty     = empty;

endmodule

// File: tb/tb_lane_arbiter.sv
// Scoreboard bench for lane_arbiter: expectations are queued as stimulus is driven
// and popped against grant/count/full/empty once the clock has advanced.
module tb_lane_arbiter;
    import lane_pkg::*;

    localparam int CAP = 7;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    lane_arbiter_if #(.COUNT_W(3)) lane ();

    lane_arbiter #(
        .CAPACITY (7),
        .COUNT_W  (3),
        .TIMEOUT  (16),
        .TIMER_W  (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .lane  (lane)
    );

    typedef struct {
        string tag;
        logic  gi;
        logic  go;
        int    cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic gi, input logic go, input int cnt);
        exp_t e;
        e.tag = tag;
        e.gi  = gi;
        e.go  = go;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Advance n cycles, then compare every queued expectation against the outputs.
    task automatic step(input int n);
        exp_t e;
        repeat (n) @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".grant_in"},  32'(lane.grant_in),  32'(e.gi));
            chk({e.tag, ".grant_out"}, 32'(lane.grant_out), 32'(e.go));
            chk({e.tag, ".count"},     32'(lane.count),     32'(e.cnt));
            chk({e.tag, ".full"},      32'(lane.full),      32'(e.cnt == CAP));
            chk({e.tag, ".empty"},     32'(lane.empty),     32'(e.cnt == 0));
        end
    endtask

    task automatic sens(input logic [1:0] ab);
        {lane.sensor_a, lane.sensor_b} = ab;
    endtask

    task automatic enter_car(input string tag, input int c, input bit keep);
        lane.req_in = 1'b1;
        sb_push({tag, ".grant"}, 1'b1, 1'b0, c);     step(1);
        sens(A_ONLY); sb_push({tag, ".a"},  1'b1, 1'b0, c); step(2);
        sens(BOTH);   sb_push({tag, ".ab"}, 1'b1, 1'b0, c); step(2);
        sens(B_ONLY); sb_push({tag, ".b"},  1'b1, 1'b0, c); step(2);
        sens(CLEAR);  sb_push({tag, ".done"}, 1'b0, 1'b0, c + 1); step(1);
        if (!keep) lane.req_in = 1'b0;
    endtask

    task automatic exit_car(input string tag, input int c, input bit keep);
        lane.req_out = 1'b1;
        sb_push({tag, ".grant"}, 1'b0, 1'b1, c);     step(1);
        sens(B_ONLY); sb_push({tag, ".b"},  1'b0, 1'b1, c); step(2);
        sens(BOTH);   sb_push({tag, ".ba"}, 1'b0, 1'b1, c); step(2);
        sens(A_ONLY); sb_push({tag, ".a"},  1'b0, 1'b1, c); step(2);
        sens(CLEAR);  sb_push({tag, ".done"}, 1'b0, 1'b0, c - 1); step(1);
        if (!keep) lane.req_out = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        lane.req_in  = 1'b0;
        lane.req_out = 1'b0;
        sens(CLEAR);
        sb_push("reset", 1'b0, 1'b0, 0);
        step(2);
        reset = 1'b0;
        sb_push("post_reset", 1'b0, 1'b0, 0);
        step(2);

        // Single entry from empty.
        enter_car("entry1", 0, 1'b0);

        // Fill to capacity, then entry must be refused.
        for (int i = 1; i < CAP; i++) enter_car("fill", i, 1'b0);
        lane.req_in = 1'b1;
        sb_push("full_block", 1'b0, 1'b0, CAP);
        step(3);
        exit_car("drain_full", CAP, 1'b0);
        sb_push("regrant_in", 1'b1, 1'b0, CAP - 1);
        step(1);
        lane.req_in = 1'b0;
        sb_push("abandon_in", 1'b0, 1'b0, CAP - 1);
        step(1);

        // Down to 3, last grant was an exit, so a tie starts with entry.
        for (int i = CAP - 1; i > 3; i--) exit_car("down", i, 1'b0);
        lane.req_in  = 1'b1;
        lane.req_out = 1'b1;
        enter_car("tie1_in", 3, 1'b1);
        exit_car("tie2_out", 4, 1'b1);
        enter_car("tie3_in", 3, 1'b1);
        lane.req_in  = 1'b0;
        lane.req_out = 1'b0;
        sb_push("tie_idle", 1'b0, 1'b0, 4);
        step(2);
        exit_car("to3", 4, 1'b0);

        // Backout then timeout.
        lane.req_in = 1'b1;
        sb_push("bo.grant", 1'b1, 1'b0, 3); step(1);
        sens(A_ONLY); sb_push("bo.a", 1'b1, 1'b0, 3); step(2);
        sens(CLEAR);  sb_push("bo.back", 1'b1, 1'b0, 3); step(1);
        sb_push("to.hold", 1'b1, 1'b0, 3);   step(15);
        sb_push("to.expire", 1'b0, 1'b0, 3); step(1);
        lane.req_in = 1'b0;
        sb_push("to.idle", 1'b0, 1'b0, 3);   step(2);

        // Exit refused when empty; exit-shaped noise must not move count.
        for (int i = 3; i > 0; i--) exit_car("empty_drain", i, 1'b0);
        lane.req_out = 1'b1;
        sb_push("empty.block", 1'b0, 1'b0, 0); step(4);
        sens(B_ONLY); sb_push("empty.noise_b",  1'b0, 1'b0, 0); step(2);
        sens(BOTH);   sb_push("empty.noise_ba", 1'b0, 1'b0, 0); step(2);
        sens(A_ONLY); sb_push("empty.noise_a",  1'b0, 1'b0, 0); step(2);
        sens(CLEAR);  sb_push("empty.noise_c",  1'b0, 1'b0, 0); step(2);
        lane.req_out = 1'b0;

        // Reset in the middle of an entry pass at count 5.
        for (int i = 0; i < 5; i++) enter_car("to5", i, 1'b0);
        lane.req_in = 1'b1;
        sb_push("mid.grant", 1'b1, 1'b0, 5); step(1);
        sens(A_ONLY); sb_push("mid.a",  1'b1, 1'b0, 5); step(2);
        sens(BOTH);   sb_push("mid.ab", 1'b1, 1'b0, 5); step(2);
        reset       = 1'b1;
        lane.req_in = 1'b0;
        sb_push("mid.reset", 1'b0, 1'b0, 0); step(1);
        reset = 1'b0;
        sens(B_ONLY); sb_push("mid.ignore_b", 1'b0, 1'b0, 0); step(2);
        sens(CLEAR);  sb_push("mid.ignore_c", 1'b0, 1'b0, 0); step(2);
        enter_car("after_reset", 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
